// File: rtl/framebuffer_arbiter_pkg.sv
// rtl/framebuffer_arbiter_pkg.sv - shared framebuffer geometry and RAM ownership type
package framebuffer_arbiter_pkg;

  // Must agree with the display fetch block driving the same RAM.
  localparam int FB_ADDR_WIDTH   = 11;
  localparam int FB_DATA_WIDTH   = 16;
  localparam int FB_FETCH_CYCLES = 4;
  localparam int FB_WR_DEPTH     = 4;

  typedef enum logic [1:0] {
    OWNER_IDLE,
    OWNER_DISP,
    OWNER_HOST
  } ram_owner_e;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// rtl/framebuffer_arbiter_if.sv - host pixel-write channel into the arbiter
interface framebuffer_arbiter_if
  import framebuffer_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH = FB_DATA_WIDTH
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_address,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_address,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/framebuffer_arbiter_write_fifo.sv
// rtl/framebuffer_arbiter_write_fifo.sv - synchronous host write FIFO with occupancy output
module framebuffer_arbiter_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push   = push && (level != LW'(DEPTH));
  assign do_pop    = pop && (level != '0);
  assign head_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - shares the framebuffer RAM between display fetch and host writes
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int FETCH_CYCLES = FB_FETCH_CYCLES,
  parameter int WR_DEPTH     = FB_WR_DEPTH,
  parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
  parameter int DATA_WIDTH   = FB_DATA_WIDTH
) (
  input  logic                      clk_in,
  input  logic                      reset_n,
  input  logic                      disp_start,
  input  logic [ADDR_WIDTH-1:0]     disp_address,
  input  logic                      disp_clk_enable,
  framebuffer_arbiter_if.slave      wr,
  output logic [ADDR_WIDTH-1:0]     ram_address,
  output logic [DATA_WIDTH-1:0]     ram_data_out,
  output logic                      ram_write_enable,
  output logic                      ram_clk_enable,
  output logic                      ram_reset,
  output logic                      disp_busy,
  output logic [$clog2(WR_DEPTH):0] wr_level,
  output logic                      overlap_error
);

  localparam int CNT_W = $clog2(FETCH_CYCLES + 1);
  localparam int LW    = $clog2(WR_DEPTH) + 1;

  logic [CNT_W-1:0]      win_cnt;
  logic                  disp_sel;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] head_address;
  logic [DATA_WIDTH-1:0] head_data;
  ram_owner_e            owner;

  framebuffer_arbiter_write_fifo #(
    .DEPTH (WR_DEPTH),
    .WIDTH (ADDR_WIDTH + DATA_WIDTH)
  ) u_write_fifo (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({wr.wr_address, wr.wr_data}),
    .pop       (pop),
    .head_data ({head_address, head_data}),
    .level     (wr_level)
  );

  assign ram_reset   = ~reset_n;
  assign wr.wr_ready = reset_n && (wr_level != LW'(WR_DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  // Gated by reset_n so a stray disp_start cannot clock the RAM during reset.
  assign disp_sel    = reset_n && (disp_start || (win_cnt != '0));
  assign disp_busy   = disp_sel;
  assign pop         = (owner == OWNER_HOST);

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt       <= '0;
      overlap_error <= 1'b0;
    end else if (disp_start) begin
      win_cnt <= CNT_W'(FETCH_CYCLES - 1);
      if (win_cnt != '0) overlap_error <= 1'b1;
    end else if (win_cnt != '0) begin
      win_cnt <= win_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    owner = OWNER_IDLE;
    if (disp_sel) begin
      owner = OWNER_DISP;
    end else if (wr_level != '0) begin
      owner = OWNER_HOST;
    end
  end

  always_comb begin
    ram_address      = disp_address;
    ram_data_out     = '0;
    ram_write_enable = 1'b0;
    ram_clk_enable   = 1'b0;
    case (owner)
      OWNER_DISP: begin
        ram_clk_enable = disp_clk_enable;
      end
      OWNER_HOST: begin
        ram_address      = head_address;
        ram_data_out     = head_data;
        ram_write_enable = 1'b1;
        ram_clk_enable   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - randomized and directed bench against a queue-based reference model
module tb_framebuffer_arbiter;
  import framebuffer_arbiter_pkg::*;

  localparam int FETCH = FB_FETCH_CYCLES;
  localparam int DEPTH = FB_WR_DEPTH;

  typedef struct packed {
    logic [FB_ADDR_WIDTH-1:0] a;
    logic [FB_DATA_WIDTH-1:0] d;
  } wr_t;

  logic                     clk_in = 1'b0;
  logic                     reset_n;
  logic                     disp_start;
  logic [FB_ADDR_WIDTH-1:0] disp_address;
  logic                     disp_clk_enable;
  logic [FB_ADDR_WIDTH-1:0] ram_address;
  logic [FB_DATA_WIDTH-1:0] ram_data_out;
  logic                     ram_write_enable;
  logic                     ram_clk_enable;
  logic                     ram_reset;
  logic                     disp_busy;
  logic [$clog2(DEPTH):0]   wr_level;
  logic                     overlap_error;

  framebuffer_arbiter_if wr ();

  framebuffer_arbiter dut (
    .clk_in           (clk_in),
    .reset_n          (reset_n),
    .disp_start       (disp_start),
    .disp_address     (disp_address),
    .disp_clk_enable  (disp_clk_enable),
    .wr               (wr),
    .ram_address      (ram_address),
    .ram_data_out     (ram_data_out),
    .ram_write_enable (ram_write_enable),
    .ram_clk_enable   (ram_clk_enable),
    .ram_reset        (ram_reset),
    .disp_busy        (disp_busy),
    .wr_level         (wr_level),
    .overlap_error    (overlap_error)
  );

  always #5 clk_in = ~clk_in;

  int     n_vec = 0;
  int     n_err = 0;
  wr_t    q[$];
  longint cyc = 0;
  longint win_until = -1;
  bit     ovf_m = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive inputs after the edge, compare at negedge, advance the model at posedge.
  task automatic step(input bit ds, input logic [FB_ADDR_WIDTH-1:0] da, input bit dce,
                      input bit wv, input logic [FB_ADDR_WIDTH-1:0] wa,
                      input logic [FB_DATA_WIDTH-1:0] wd);
    bit  busy, ready, issue;
    wr_t item;
    disp_start      = ds;
    disp_address    = da;
    disp_clk_enable = dce;
    wr.wr_valid     = wv;
    wr.wr_address   = wa;
    wr.wr_data      = wd;
    @(negedge clk_in);
    busy  = ds || (cyc <= win_until);
    ready = q.size() < DEPTH;
    issue = !busy && (q.size() > 0);
    chk_val("wr_ready", wr.wr_ready, ready);
    chk_val("wr_level", wr_level, q.size());
    chk_val("disp_busy", disp_busy, busy);
    chk_val("ram_reset", ram_reset, 0);
    chk_val("overlap_error", overlap_error, ovf_m);
    chk_val("ram_write_enable", ram_write_enable, issue);
    if (busy) begin
      chk_val("disp_address", ram_address, da);
      chk_val("disp_clk_enable", ram_clk_enable, dce);
      chk_val("disp_data_out", ram_data_out, 0);
    end else if (issue) begin
      chk_val("wr_address", ram_address, q[0].a);
      chk_val("wr_data", ram_data_out, q[0].d);
      chk_val("wr_clk_enable", ram_clk_enable, 1);
    end else begin
      chk_val("idle_address", ram_address, da);
      chk_val("idle_clk_enable", ram_clk_enable, 0);
    end
    @(posedge clk_in);
    if (ds) begin
      if (cyc <= win_until) ovf_m = 1'b1;
      win_until = cyc + FETCH - 1;
    end
    if (issue) void'(q.pop_front());
    if (wv && ready) begin
      item.a = wa;
      item.d = wd;
      q.push_back(item);
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 11'h000, 0, 0, 11'h000, 16'h0000);
  endtask

  // Reset is asserted between clock edges to exercise the asynchronous path.
  task automatic do_reset();
    @(posedge clk_in);
    #2;
    disp_start  = 1'b0;
    wr.wr_valid = 1'b0;
    reset_n     = 1'b0;
    #1;
    chk_val("rst_wr_ready", wr.wr_ready, 0);
    chk_val("rst_wr_level", wr_level, 0);
    chk_val("rst_ram_we", ram_write_enable, 0);
    chk_val("rst_ram_ce", ram_clk_enable, 0);
    chk_val("rst_ram_reset", ram_reset, 1);
    chk_val("rst_disp_busy", disp_busy, 0);
    chk_val("rst_overlap", overlap_error, 0);
    q.delete();
    win_until = -1;
    ovf_m     = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    disp_start      = 1'b0;
    disp_address    = '0;
    disp_clk_enable = 1'b0;
    wr.wr_valid     = 1'b0;
    wr.wr_address   = '0;
    wr.wr_data      = '0;
    do_reset();

    // Idle after release
    idle(10);

    // Single write with no display activity
    step(0, 11'h010, 0, 1, 11'h155, 16'hF800);
    idle(3);

    // Four writes queued; display window preempts the first issue slot
    step(0, 11'h020, 1, 1, 11'h001, 16'h1111);
    step(1, 11'h021, 1, 1, 11'h002, 16'h2222);
    step(0, 11'h022, 0, 1, 11'h003, 16'h3333);
    step(0, 11'h023, 1, 1, 11'h004, 16'h4444);
    step(0, 11'h024, 1, 0, 11'h000, 16'h0000);
    idle(6);

    // disp_start held high: FIFO fills, fifth write refused, overlap flagged
    for (int i = 0; i < 8; i++)
      step(1, 11'h030 + 11'(i), 1, 1, 11'h040 + 11'(i), 16'hA000 + 16'(i));
    idle(8);

    // Reset mid-window with three queued writes
    step(1, 11'h050, 1, 1, 11'h060, 16'hB001);
    step(0, 11'h051, 1, 1, 11'h061, 16'hB002);
    step(0, 11'h052, 1, 1, 11'h062, 16'hB003);
    do_reset();
    idle(6);

    // Reach level 2 behind a window, then push while popping across pointer wrap
    step(1, 11'h070, 1, 1, 11'h100, 16'hC000);
    step(0, 11'h071, 1, 1, 11'h101, 16'hC001);
    step(0, 11'h072, 1, 0, 11'h000, 16'h0000);
    step(0, 11'h073, 1, 0, 11'h000, 16'h0000);
    for (int i = 2; i < 12; i++)
      step(0, 11'h074, 0, 1, 11'h100 + 11'(i), 16'hC000 + 16'(i));
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(5) == 0), 11'($urandom), 1'($urandom),
           ($urandom_range(2) != 0), 11'($urandom), 16'($urandom));
      if ($urandom_range(199) == 0) do_reset();
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

endmodule

// File: doc/framebuffer_arbiter.md
Name: framebuffer_arbiter

Overview:
Shares the single-port framebuffer RAM (11-bit address, 16-bit data) between the display fetch path and a host pixel-write path.
- Display fetch has absolute priority. It owns the RAM for a fixed window after each pixel load start.
- Host writes are buffered in a small FIFO and issued in idle cycles, one write per cycle.
- Sits between the framebuffer fetch block, the host write interface (SPI/UART decoder) and the RAM primitive.

Parameters:
FETCH_CYCLES, 4, length of the display window in clk_in cycles, counted from the cycle disp_start is high.
WR_DEPTH, 4, host write FIFO depth; power of two, at least 2.
ADDR_WIDTH, 11, RAM address width.
DATA_WIDTH, 16, RAM data width (RGB565).

Ports:
clk_in  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
disp_start  input  1  pixel load start pulse from the fetch controller
disp_address  input  ADDR_WIDTH  read address driven by the fetch block
disp_clk_enable  input  1  RAM clock enable requested by the fetch block
wr_valid  input  1  host write request
wr_ready  output  1  FIFO can accept a write
wr_address  input  ADDR_WIDTH  host write address
wr_data  input  DATA_WIDTH  host write pixel
ram_address  output  ADDR_WIDTH  muxed RAM address
ram_data_out  output  DATA_WIDTH  RAM write data
ram_write_enable  output  1  RAM write strobe
ram_clk_enable  output  1  RAM clock enable
ram_reset  output  1  active-high RAM reset, equal to ~reset_n
disp_busy  output  1  display window active
wr_level  output  clog2(WR_DEPTH)+1  FIFO occupancy
overlap_error  output  1  sticky flag: disp_start arrived while a display window was still open

Behaviour:
Reset (reset_n low, asynchronous):
- FIFO flushed; wr_level=0; window counter=0; overlap_error=0.
- Outputs: wr_ready=0 while in reset, 1 from the first cycle after release; ram_write_enable=0; ram_clk_enable=0; ram_reset=1.

Display window:
- win_cnt is loaded with FETCH_CYCLES-1 on a rising edge where disp_start=1, then decrements to 0.
- disp_sel = disp_start OR (win_cnt != 0). This is combinational, so the window covers the disp_start cycle plus FETCH_CYCLES-1 further cycles.
- disp_busy = disp_sel.
- While disp_sel=1: ram_address=disp_address, ram_clk_enable=disp_clk_enable, ram_write_enable=0, ram_data_out=0.
- disp_start while win_cnt != 0: counter reloads (window extends) and overlap_error is set. overlap_error clears only on reset.

Write issue:
- Applies when disp_sel=0 and wr_level != 0.
- Outputs: ram_address=head address, ram_data_out=head data, ram_write_enable=1, ram_clk_enable=1.
- The head is popped at the end of that cycle.
- Because the mux is combinational, disp_start preempts a write in the same cycle. That write is not popped and is retried later, so writes never overlap a display window.

Idle:
- Applies when disp_sel=0 and the FIFO is empty.
- ram_address=disp_address, ram_clk_enable=0, ram_write_enable=0.

FIFO:
- wr_ready = (wr_level != WR_DEPTH), derived from the registered level.
- Push on wr_valid & wr_ready.
- Simultaneous push and pop leaves wr_level unchanged. When the FIFO is full, wr_ready is low, so no push occurs.
- Pointers wrap modulo WR_DEPTH.
- Writes issue in FIFO order.
- Latency: a write accepted at edge N reaches the RAM in cycle N+1 at the earliest, if that cycle is idle.

Throughput: one RAM write per non-display cycle. Display windows every FETCH_CYCLES cycles fully starve writes. This is allowed; wr_ready backpressures the host.

Decomposition:
- Shared package/header holds ADDR_WIDTH, DATA_WIDTH and the FETCH_CYCLES default. These match the values used by the fetch block.
- One natural sub-module: write_fifo (synchronous FIFO with level output and parameterised depth/width). The arbiter top contains the window counter, the mux and the error flag.

Test Plan:
1. Reset release, then idle for 10 cycles: wr_ready=1, wr_level=0, ram_write_enable=0, ram_clk_enable=0, ram_reset=0.
2. Single write (addr 0x155, data 0xF800) with no display activity: wr_level goes to 1, the next cycle shows ram_write_enable=1, ram_address=0x155, ram_data_out=0xF800, then wr_level=0.
3. Four writes queued, then disp_start pulsed in the cycle the first write would issue:
   - no ram_write_enable for 4 cycles, and ram_address follows disp_address;
   - the writes then issue in order on 4 consecutive cycles.
4. Fill the FIFO with disp_start held continuously high:
   - wr_ready=0 at wr_level=4; a fifth wr_valid is not accepted;
   - overlap_error=1 after the second disp_start;
   - after disp_start drops, the FIFO drains.
5. Assert reset_n low mid-window with 3 queued writes: FIFO empty, disp_busy=0 and overlap_error=0 immediately, and no RAM write after release.
6. Simultaneous push and pop at wr_level=2: wr_level stays 2 and FIFO order is preserved across pointer wrap-around, checked with 12 sequential addresses.
